// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_decoder
// Rebuilds a stable two-digit value from a scanned 7-segment bus.
// Option  : SEG_DP_CAPTURE_EN adds dp_out (decimal points published with value)
// Revision: 1.0
// ============================================================================
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int STABLE_FRAMES  = 3,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    input  logic [1:0] sel_in,
    output logic [3:0] value_tens,
    output logic [3:0] value_ones,
    output logic [6:0] value_bin,
    output logic       value_valid,
    output logic       decode_err,
`ifdef SEG_DP_CAPTURE_EN
    output logic [1:0] dp_out,
`endif
    output logic       stale
);

    localparam int            TW          = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    MATCH_MAX   = 4'(STABLE_FRAMES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [7:0]    seg_m, sseg;
    logic [1:0]    sel_m, ssel, ssel_d;
    logic [1:0]    state, state_nx;
    logic [7:0]    settle_cnt;
    logic          settle_load, sample;
    logic          sel_chg, sel_legal, sel_bad_entry;
    logic [4:0]    dec;
    logic          good_cap, bad_cap;
    logic [3:0]    slot_tens, slot_ones;
    logic          flag_tens, flag_ones;
    logic [7:0]    cand, cand_prev;
    logic [3:0]    match_cnt, match_nx;
    logic [TW-1:0] timeout_cnt;
    logic          frame, publish, timeout_hit;
    logic          dp_same, dp_pub_diff;
    logic [3:0]    tens_b, ones_b;
    logic [6:0]    bin_nx;

    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h40:   seg_decode = {1'b1, 4'd0};
            7'h79:   seg_decode = {1'b1, 4'd1};
            7'h24:   seg_decode = {1'b1, 4'd2};
            7'h30:   seg_decode = {1'b1, 4'd3};
            7'h19:   seg_decode = {1'b1, 4'd4};
            7'h12:   seg_decode = {1'b1, 4'd5};
            7'h02:   seg_decode = {1'b1, 4'd6};
            7'h78:   seg_decode = {1'b1, 4'd7};
            7'h00:   seg_decode = {1'b1, 4'd8};
            7'h10:   seg_decode = {1'b1, 4'd9};
            7'h7F:   seg_decode = {1'b1, 4'hF};
            default: seg_decode = {1'b0, 4'h0};
        endcase
    endfunction

    // Synchronisers reset to the idle pattern so reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m  <= 8'hFF;
            sseg   <= 8'hFF;
            sel_m  <= 2'b11;
            ssel   <= 2'b11;
            ssel_d <= 2'b11;
        end else begin
            seg_m  <= seg_in;
            sseg   <= seg_m;
            sel_m  <= sel_in;
            ssel   <= sel_m;
            ssel_d <= ssel;
        end
    end

    assign sel_chg       = (ssel != ssel_d);
    assign sel_legal     = (ssel == 2'b10) || (ssel == 2'b01);
    assign sel_bad_entry = sel_chg && (ssel == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (sel_chg && sel_legal) state_nx = S_SETTLE;
            S_SETTLE: begin
                if (sel_chg)                 state_nx = sel_legal ? S_SETTLE : S_IDLE;
                else if (settle_cnt == 8'd0) state_nx = S_HOLD;
            end
            S_HOLD:   if (sel_chg) state_nx = sel_legal ? S_SETTLE : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        settle_load = sel_chg && sel_legal;
        sample      = (state == S_SETTLE) && !sel_chg && (settle_cnt == 8'd0);
    end

    assign dec      = seg_decode(sseg[6:0]);
    assign good_cap = sample && dec[4];
    assign bad_cap  = sample && !dec[4];

    assign frame    = flag_tens && flag_ones;
    assign cand     = {slot_tens, slot_ones};
    assign match_nx = ((cand == cand_prev) && dp_same)
                      ? ((match_cnt >= MATCH_MAX) ? MATCH_MAX : match_cnt + 4'd1)
                      : 4'd1;
    assign publish  = frame && (match_nx == MATCH_MAX) &&
                      ((cand != {value_tens, value_ones}) || dp_pub_diff || stale);
    // A capture in the timeout cycle restarts the count instead.
    assign timeout_hit = !good_cap && (timeout_cnt == TO_LAST);

    assign tens_b = (cand[7:4] == 4'hF) ? 4'd0 : cand[7:4];
    assign ones_b = (cand[3:0] == 4'hF) ? 4'd0 : cand[3:0];
    assign bin_nx = 7'(tens_b) * 7'd10 + 7'(ones_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt  <= 8'd0;
            timeout_cnt <= '0;
            slot_tens   <= 4'd0;
            slot_ones   <= 4'd0;
            flag_tens   <= 1'b0;
            flag_ones   <= 1'b0;
            cand_prev   <= 8'd0;
            match_cnt   <= 4'd0;
            value_tens  <= 4'hF;
            value_ones  <= 4'hF;
            value_bin   <= 7'd0;
            value_valid <= 1'b0;
            decode_err  <= 1'b0;
            stale       <= 1'b1;
        end else begin
            value_valid <= publish;
            decode_err  <= bad_cap || sel_bad_entry;

            if (settle_load)                                  settle_cnt <= SETTLE_LOAD;
            else if (state == S_SETTLE && settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;

            if (good_cap)                    timeout_cnt <= '0;
            else if (timeout_cnt != TO_LAST) timeout_cnt <= timeout_cnt + TW'(1);

            if (frame) begin
                flag_tens <= 1'b0;
                flag_ones <= 1'b0;
                cand_prev <= cand;
                match_cnt <= match_nx;
            end
            if (good_cap) begin
                if (ssel == 2'b10) begin
                    slot_ones <= dec[3:0];
                    flag_ones <= 1'b1;
                end else begin
                    slot_tens <= dec[3:0];
                    flag_tens <= 1'b1;
                end
            end
            if (bad_cap) match_cnt <= 4'd0;

            if (publish) begin
                value_tens <= cand[7:4];
                value_ones <= cand[3:0];
                value_bin  <= bin_nx;
                stale      <= 1'b0;
            end
            if (timeout_hit) begin
                stale     <= 1'b1;
                match_cnt <= 4'd0;
                flag_tens <= 1'b0;
                flag_ones <= 1'b0;
            end
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    logic       dp_tens, dp_ones;
    logic [1:0] dp_prev;

    assign dp_same     = ({dp_tens, dp_ones} == dp_prev);
    assign dp_pub_diff = ({dp_tens, dp_ones} != dp_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_tens <= 1'b0;
            dp_ones <= 1'b0;
            dp_prev <= 2'b00;
            dp_out  <= 2'b00;
        end else begin
            if (good_cap) begin
                if (ssel == 2'b10) dp_ones <= ~sseg[7];
                else               dp_tens <= ~sseg[7];
            end
            if (frame)   dp_prev <= {dp_tens, dp_ones};
            if (publish) dp_out  <= {dp_tens, dp_ones};
        end
    end
`else
    logic unused_dp;
    assign unused_dp   = sseg[7];
    assign dp_same     = 1'b1;
    assign dp_pub_diff = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the multiplexed two-digit 7-segment driver. It samples the scanned segment/select lines, for example from a loopback header or a second board, and rebuilds the displayed two-digit value. Each digit is decoded back to BCD and filtered for stability. A clean value is published with a one-cycle valid pulse. Used for on-board self-check of the countdown display and as a bench monitor.

Parameters:
SETTLE_CYCLES, 16, cycles a legal select must stay unchanged before segments are sampled (range 1..255).
STABLE_FRAMES, 3, number of consecutive identical frames required before a value is published (range 1..15).
TIMEOUT_CYCLES, 1048576, cycles without any digit capture before `stale` asserts.

Ports:
clk  in  1  system clock
rst_n  in  1  async reset, active low
seg_in  in  8  segment lines {dp,g,f,e,d,c,b,a}, common anode, 0 = lit
sel_in  in  2  digit select, active low; 2'b10 = ones digit, 2'b01 = tens digit
value_tens  out  4  published tens BCD; 4'hF = blank
value_ones  out  4  published ones BCD; 4'hF = blank
value_bin  out  7  published binary value 0..99; a blank digit counts as 0
value_valid  out  1  1-cycle pulse when a new value is published
decode_err  out  1  1-cycle pulse on an illegal segment pattern or illegal select
stale  out  1  high while no valid scan activity is seen

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - value_tens = value_ones = 4'hF, value_bin = 0.
  - value_valid = 0, decode_err = 0, stale = 1.
  - FSM = IDLE; all counters and slot flags = 0.
- Synchronisation: seg_in and sel_in pass through a 2-flop synchroniser. All logic below uses the synchronised copies (sseg, ssel).
- Select classification:
  - ssel 2'b10 selects the ones slot; 2'b01 selects the tens slot.
  - 2'b11 is idle: no capture, no error.
  - 2'b00 is illegal: decode_err pulses once on entry, then it is treated as idle.
- FSM states:
  - IDLE: on ssel changing to a legal value, load settle_cnt = SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: decrement settle_cnt each cycle. If ssel changes, restart SETTLE (new legal value) or go to IDLE (idle/illegal). When settle_cnt = 0 with ssel unchanged, sample sseg and go to HOLD.
  - HOLD: exactly one sample is taken per select period. Leave HOLD only on an ssel change, with the same handling as IDLE.
- Segment decode:
  - The dp bit is ignored. Low 7 bits: 0x40=0, 0x79=1, 0x24=2, 0x30=3, 0x19=4, 0x12=5, 0x02=6, 0x78=7, 0x00=8, 0x10=9, 0x7F=blank (4'hF).
  - Any other pattern: decode_err pulses, the slot is not written, and match_cnt is cleared.
- Frame assembly:
  - A good sample writes its slot digit and sets that slot's flag.
  - When both flags are set, the cycle after the second write forms candidate {tens,ones} and clears both flags.
- Stability filter:
  - If candidate equals the previous candidate, match_cnt increments, saturating at STABLE_FRAMES; otherwise match_cnt = 1.
  - When match_cnt reaches STABLE_FRAMES and candidate differs from the published value, or stale = 1, update the outputs and pulse value_valid in the same cycle.
  - An unchanged value does not pulse again.
- Latency: value_valid asserts 1 cycle after the qualifying capture. Each capture occurs SETTLE_CYCLES+2 cycles after the raw select edge.
- value_bin = 10*tens + ones, computed with 7-bit arithmetic and blank mapped to 0.
- Timeout and stale:
  - timeout_cnt clears on every good capture.
  - On reaching TIMEOUT_CYCLES-1: stale = 1, match_cnt = 0, slot flags cleared. Published values are held.
  - stale clears only on the next publish.
- Simultaneous events: an illegal pattern on the frame-completing sample means no frame is formed. A timeout in the same cycle as a capture is won by the capture.
- Async reset mid-operation returns every output and state to its reset value immediately.

Optional Feature:
SEG_DP_CAPTURE_EN
- Defined: adds output `dp_out [1:0]` = {tens dp lit, ones dp lit}. Lit means sampled dp = 0. It is published with the value, reset value 2'b00, and dp is included in the candidate comparison.
- Undefined: the port is absent and dp is ignored entirely.

Test Plan:
- STABLE_FRAMES=3, SETTLE=16; alternate sel 2'b10/seg 0x92 and sel 2'b01/seg 0xA4, 64 cycles each -> one value_valid after the 3rd frame; tens=2, ones=5, bin=25, stale falls.
- Continue scanning "25", then switch to "24" (0x99 on ones) -> no pulse while 25 holds; exactly one pulse after 3 frames of 24, bin=24.
- Tens seg 0xFF, ones 0xB0 -> tens=4'hF, ones=3, bin=3, valid pulses.
- Inject seg 0x55 on one ones period -> decode_err 1 cycle; match_cnt resets; publish delayed to 3 frames after the fault.
- Toggle sel every 8 cycles with SETTLE=16 -> no captures, no valid; after TIMEOUT_CYCLES, stale=1 and value held.
- Assert rst_n low mid-SETTLE -> outputs at reset values at once; after release, the first value needs the full 3 frames.
